// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_arb_pkg;

    localparam int ARB_NUM_REQ = 2;
    localparam int ARB_ADDR_W  = 64;
    localparam int ARB_DATA_W  = 64;
    localparam int GRANT_W     = $clog2(ARB_NUM_REQ);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    // Request fields captured at grant time and replayed on the AR channel
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
    } ar_req_t;

    // Beat counter increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] beat_cnt_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Combinational round-robin picker: searches upward from the requester after last_grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GRANT_W = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] grant,
    output logic               any_req
);

    // First requester found at offsets 1..NUM_REQ from last_grant wins
    always_comb begin
        grant   = last_grant;
        any_req = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_req && req[j] && (j == ((int'(last_grant) + i) % NUM_REQ))) begin
                    any_req = 1'b1;
                    grant   = GRANT_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between the icache and dcache line fills,
// one outstanding burst at a time, round-robin between requesters.
// The latched request record uses the package widths, so ADDR_W must stay
// equal to ARB_ADDR_W.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]      req_arlen,
    input  logic [NUM_REQ*3-1:0]      req_arsize,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [NUM_REQ-1:0]        req_rlast,
    output logic [DATA_W-1:0]         req_rdata,
    input  logic [NUM_REQ-1:0]        req_rready,
    output logic                      m_axi_arvalid,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    input  logic                      m_axi_arready,
    input  logic                      m_axi_rvalid,
    input  logic                      m_axi_rlast,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    output logic                      m_axi_rready,
    output logic                      rlast_err
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        state;
    arb_state_e        next_state;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     pick;
    logic              any_req;
    ar_req_t           req_q;
    logic [7:0]        beat_cnt;
    logic              beat;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_len;
    logic [2:0]        sel_size;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GW)
    ) u_rr (
        .req        (req_arvalid),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    // Select the AR fields of the requester the arbiter is picking this cycle
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == GW'(j)) begin
                sel_addr = req_araddr[j*ADDR_W +: ADDR_W];
                sel_len  = req_arlen[j*8 +: 8];
                sel_size = req_arsize[j*3 +: 3];
            end
        end
    end

    assign beat          = (state == ARB_DATA) && m_axi_rvalid && m_axi_rready;
    assign req_rdata     = m_axi_rdata;
    assign m_axi_araddr  = req_q.addr;
    assign m_axi_arlen   = req_q.len;
    assign m_axi_arsize  = req_q.size;

    // Next-state and handshake outputs; grants are withheld while reset is held low
    always_comb begin
        next_state    = state;
        req_arready   = '0;
        req_rvalid    = '0;
        req_rlast     = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any_req && reset) begin
                    req_arready[pick] = 1'b1;
                    next_state        = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    next_state = ARB_DATA;
                end
            end
            ARB_DATA: begin
                m_axi_rready        = req_rready[grant_q];
                req_rvalid[grant_q] = m_axi_rvalid;
                req_rlast[grant_q]  = m_axi_rlast;
                if (beat && m_axi_rlast) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // State register, grant/request latch, beat counting and sticky length-error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant_q    <= '0;
            req_q      <= '0;
            beat_cnt   <= '0;
            rlast_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && any_req) begin
                grant_q    <= pick;
                req_q.addr <= sel_addr;
                req_q.len  <= sel_len;
                req_q.size <= sel_size;
            end
            if (state == ARB_ADDR && m_axi_arready) begin
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt_inc(beat_cnt);
                if (m_axi_rlast) begin
                    last_grant <= grant_q;
                    if (beat_cnt != req_q.len) begin
                        rlast_err <= 1'b1;
                    end
                end else if (beat_cnt == req_q.len) begin
                    rlast_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a table of bursts plus hand-written
// sequences for stalls, length errors and mid-burst reset.
module tb_axi_read_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;

    typedef struct {
        logic [1:0]  arvalid;
        logic [63:0] addr0;
        logic [63:0] addr1;
        logic [7:0]  len;
        int          exp_grant;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]      req_arlen;
    logic [NUM_REQ*3-1:0]      req_arsize;
    logic [NUM_REQ-1:0]        req_arready;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [NUM_REQ-1:0]        req_rlast;
    logic [DATA_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        req_rready;
    logic                      m_axi_arvalid;
    logic [ADDR_W-1:0]         m_axi_araddr;
    logic [7:0]                m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic                      m_axi_arready;
    logic                      m_axi_rvalid;
    logic                      m_axi_rlast;
    logic [DATA_W-1:0]         m_axi_rdata;
    logic                      m_axi_rready;
    logic                      rlast_err;

    int   checks   = 0;
    int   failures = 0;
    int   sent     = 0;
    logic [6:0] stall_pat;
    vec_t vecs[7];

    axi_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_arvalid   (req_arvalid),
        .req_araddr    (req_araddr),
        .req_arlen     (req_arlen),
        .req_arsize    (req_arsize),
        .req_arready   (req_arready),
        .req_rvalid    (req_rvalid),
        .req_rlast     (req_rlast),
        .req_rdata     (req_rdata),
        .req_rready    (req_rready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rready  (m_axi_rready),
        .rlast_err     (rlast_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [1:0] oh(input int g);
        return 2'b01 << g;
    endfunction

    function automatic logic [2:0] exp_size(input int g);
        return (g == 0) ? 3'd3 : 3'd2;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] arvalid, input logic [63:0] a0, input logic [63:0] a1,
                                 input logic [7:0] len);
        req_arvalid = arvalid;
        req_araddr  = {a1, a0};
        req_arlen   = {len, len};
        req_arsize  = {3'd2, 3'd3};
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the AR handshake edge
    task automatic grantAndAddr(input logic [1:0] arvalid, input logic [63:0] a0, input logic [63:0] a1,
                                input logic [7:0] len, input int g);
        applyStimulus(arvalid, a0, a1, len);
        @(negedge clk);
        checkOutput("arready_grant", {62'd0, req_arready}, {62'd0, oh(g)});
        checkOutput("arvalid_idle", {63'd0, m_axi_arvalid}, 64'd0);
        @(posedge clk);
        #1;
        req_arvalid = '0;
        @(negedge clk);
        checkOutput("ar_fields", {52'd0, m_axi_arvalid, m_axi_arlen, m_axi_arsize}, {52'd0, 1'b1, len, exp_size(g)});
        checkOutput("araddr", m_axi_araddr, (g == 0) ? a0 : a1);
        checkOutput("arready_quiet", {62'd0, req_arready}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ar_hold", {m_axi_araddr[59:0], 3'd0, m_axi_arvalid}, {((g == 0) ? a0[59:0] : a1[59:0]), 3'd0, 1'b1});
        m_axi_arready = 1'b1;
        @(posedge clk);
        #1;
        m_axi_arready = 1'b0;
    endtask

    // One accepted beat from the slave; checks routing to requester g
    task automatic sendBeat(input int g, input logic last, input logic [63:0] data);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = last;
        m_axi_rdata  = data;
        req_rready   = 2'b11;
        @(negedge clk);
        checkOutput("beat_route", {59'd0, req_rvalid, req_rlast, m_axi_rready},
                    {59'd0, oh(g), (last ? oh(g) : 2'b00), 1'b1});
        checkOutput("rdata", req_rdata, data);
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    task automatic runBurst(input vec_t v);
        grantAndAddr(v.arvalid, v.addr0, v.addr1, v.len, v.exp_grant);
        for (int b = 0; b <= int'(v.len); b++) begin
            sendBeat(v.exp_grant, (b == int'(v.len)), {32'hD00D_0000, 32'(b)});
        end
        checkOutput("rlast_err_clean", {63'd0, rlast_err}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{arvalid: 2'b11, addr0: 64'h1000, addr1: 64'h2000, len: 8'd3, exp_grant: 0};
        vecs[1] = '{arvalid: 2'b11, addr0: 64'h1100, addr1: 64'h2100, len: 8'd1, exp_grant: 1};
        vecs[2] = '{arvalid: 2'b11, addr0: 64'h1200, addr1: 64'h2200, len: 8'd2, exp_grant: 0};
        vecs[3] = '{arvalid: 2'b11, addr0: 64'h1300, addr1: 64'h2300, len: 8'd0, exp_grant: 1};
        vecs[4] = '{arvalid: 2'b01, addr0: 64'h1000, addr1: 64'h0,    len: 8'd7, exp_grant: 0};
        vecs[5] = '{arvalid: 2'b10, addr0: 64'h0,    addr1: 64'h2400, len: 8'd0, exp_grant: 1};
        vecs[6] = '{arvalid: 2'b10, addr0: 64'h0,    addr1: 64'h2500, len: 8'd2, exp_grant: 1};

        reset         = 1'b0;
        req_rready    = 2'b11;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rdata   = '0;
        applyStimulus(2'b11, 64'hAAAA, 64'hBBBB, 8'd5);
        #3;
        checkOutput("reset_outputs", {59'd0, req_arready, m_axi_arvalid, m_axi_rready, rlast_err}, 64'd0);

        repeat (2) @(posedge clk);
        #1;
        req_arvalid = '0;
        reset       = 1'b1;

        // Stray R beat while idle must not reach any requester
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        @(negedge clk);
        checkOutput("stray_r", {60'd0, req_rvalid, m_axi_rready, rlast_err}, 64'd0);
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;

        $display("[TB] burst table");
        for (int i = 0; i < 7; i++) begin
            runBurst(vecs[i]);
        end

        $display("[TB] requester stall");
        grantAndAddr(2'b01, 64'h3000, 64'h0, 8'd3, 0);
        stall_pat = 7'b1110001;
        sent      = 0;
        for (int c = 0; c < 7; c++) begin
            req_rready   = {1'b1, stall_pat[c]};
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = (sent == 3);
            m_axi_rdata  = 64'(sent);
            @(negedge clk);
            checkOutput("stall_route", {59'd0, req_rvalid, req_rlast, m_axi_rready},
                        {59'd0, 2'b01, ((sent == 3) ? 2'b01 : 2'b00), stall_pat[c]});
            if (stall_pat[c]) sent++;
            @(posedge clk);
            #1;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        req_rready   = 2'b11;
        checkOutput("stall_err", {63'd0, rlast_err}, 64'd0);

        $display("[TB] early rlast");
        grantAndAddr(2'b10, 64'h0, 64'h4000, 8'd3, 1);
        sendBeat(1, 1'b0, 64'h40);
        sendBeat(1, 1'b1, 64'h41);
        checkOutput("early_rlast_err", {63'd0, rlast_err}, 64'd1);
        grantAndAddr(2'b01, 64'h5000, 64'h0, 8'd0, 0);
        sendBeat(0, 1'b1, 64'h50);
        checkOutput("err_sticky", {63'd0, rlast_err}, 64'd1);

        $display("[TB] reset mid-burst");
        grantAndAddr(2'b10, 64'h0, 64'h6000, 8'd7, 1);
        for (int b = 0; b < 3; b++) begin
            sendBeat(1, 1'b0, 64'h60 + 64'(b));
        end
        m_axi_rvalid = 1'b1;
        @(negedge clk);
        checkOutput("beat4_live", {62'd0, req_rvalid}, 64'd2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", {57'd0, req_rvalid, req_rlast, m_axi_rready, m_axi_arvalid, req_arready[0], rlast_err},
                    64'd0);
        m_axi_rvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        grantAndAddr(2'b11, 64'h7000, 64'h7100, 8'd0, 0);
        sendBeat(0, 1'b1, 64'h70);
        checkOutput("post_reset_err", {63'd0, rlast_err}, 64'd0);

        $display("[TB] missing rlast");
        grantAndAddr(2'b10, 64'h0, 64'h8000, 8'd1, 1);
        sendBeat(1, 1'b0, 64'h80);
        sendBeat(1, 1'b0, 64'h81);
        checkOutput("overrun_err", {63'd0, rlast_err}, 64'd1);
        sendBeat(1, 1'b1, 64'h82);
        grantAndAddr(2'b01, 64'h9000, 64'h0, 8'd0, 0);
        sendBeat(0, 1'b1, 64'h90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
